// File: rtl/aes_pkg.sv
// Shared AES types and transform functions for aes_core_ed and aes_key_cache.
// The S-box is computed from its GF(2^8) definition (multiplicative inverse plus
// affine map), so no lookup table has to be maintained by hand.
package aes_pkg;

  localparam int unsigned MAX_NR = 14;

  // Byte 0 is the most significant byte; column c, row r is byte 4*c+r.
  typedef logic [0:15][7:0] state_t;
  typedef logic [0:3][7:0]  word_t;
  typedef logic [127:0]     round_key_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_ROUND, ST_DONE} fsm_t;

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return (key_bits == 256) ? 32'd14 : 32'd10;
  endfunction

  // Key-expansion cycles: AES-256 gets RK0/RK1 straight from the key.
  function automatic int unsigned exp_cycles_of(input int unsigned key_bits);
    return (key_bits == 256) ? 32'd13 : 32'd10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    return gf_inv(x);
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t o;
    for (int i = 0; i < 16; i++) o[i] = sbox(s[i]);
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int i = 0; i < 16; i++) o[i] = inv_sbox(s[i]);
    return o;
  endfunction

  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c+4-r)%4)+r];
    return o;
  endfunction

  // Circulant column multiply with first-row coefficients m0..m3.
  function automatic state_t mix_generic(input state_t s, input logic [7:0] m0,
                                         input logic [7:0] m1, input logic [7:0] m2,
                                         input logic [7:0] m3);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        o[4*c+i] = gf_mul(s[4*c+i], m0) ^ gf_mul(s[4*c+(i+1)%4], m1) ^
                   gf_mul(s[4*c+(i+2)%4], m2) ^ gf_mul(s[4*c+(i+3)%4], m3);
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    return mix_generic(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    return mix_generic(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t o;
    for (int i = 0; i < 4; i++) o[i] = sbox(w[i]);
    return o;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[1], w[2], w[3], w[0]};
  endfunction

  // rcon(1) = 01, doubling in GF(2^8); idx 1..10 covers both key sizes.
  function automatic logic [7:0] rcon(input int unsigned idx);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned j = 2; j <= 10; j++)
      if (j <= idx) r = xtime(r);
    return r;
  endfunction

endpackage

// File: rtl/aes_key_cache.sv
// Round-key cache: one expansion step per cycle into an (Nr+1) x 128 register
// file, plus the stored key and valid bit used for hit detection.
// Ports: key_in (live key for compare/load), load (start expansion: write RK0
// [and RK1], clear valid), step/step_idx (write RK[step_idx]), rd_idx/rd_key_c
// (combinational read port), hit_c (valid and key matches).
module aes_key_cache
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                load,
  input  logic                step,
  input  logic [3:0]          step_idx,
  input  logic [3:0]          rd_idx,
  output logic                hit_c,
  output logic [127:0]        rd_key_c
);

  localparam int unsigned NR  = nr_of(KEY_BITS);
  localparam bit          NK8 = (KEY_BITS == 256);

  round_key_t          rk_q [NR+1];
  logic [KEY_BITS-1:0] key_q;
  logic                valid_q;

  logic [3:0]          idx_prev;
  logic [3:0]          idx_base;
  logic [0:3][31:0]    base_w;
  logic [0:3][31:0]    new_w;
  word_t               last_w;
  word_t               temp_w;

  // AES-128 builds on RK(k-1); AES-256 on RK(k-2) with RK(k-1) feeding temp.
  assign idx_prev = step_idx - 4'd1;
  assign idx_base = NK8 ? (step_idx - 4'd2) : idx_prev;

  // One FIPS-197 expansion step; odd AES-256 steps are SubWord-only.
  always_comb begin
    base_w = rk_q[idx_base];
    last_w = word_t'(rk_q[idx_prev][31:0]);
    if (NK8 && step_idx[0]) begin
      temp_w = sub_word(last_w);
    end else begin
      temp_w = sub_word(rot_word(last_w)) ^
               {rcon(NK8 ? 32'(step_idx >> 1) : 32'(step_idx)), 24'h000000};
    end
    new_w[0] = base_w[0] ^ temp_w;
    new_w[1] = base_w[1] ^ new_w[0];
    new_w[2] = base_w[2] ^ new_w[1];
    new_w[3] = base_w[3] ^ new_w[2];
  end

  // Round-key storage; contents are meaningless until valid_q is set.
  always_ff @(posedge clk) begin
    if (load) begin
      rk_q[0] <= key_in[KEY_BITS-1 -: 128];
      if (NK8) rk_q[1] <= key_in[127:0];
    end else if (step) begin
      rk_q[step_idx] <= new_w;
    end
  end

  // Key tag is captured at load; valid only rises once the last key is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      key_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b0;
      key_q   <= key_in;
    end else if (step && (step_idx == 4'(NR))) begin
      valid_q <= 1'b1;
    end
  end

  assign hit_c    = valid_q && (key_q == key_in);
  assign rd_key_c = rk_q[rd_idx];

endmodule

// File: rtl/aes_core_ed.sv
// Iterative AES encrypt/decrypt core, one round per clock, with a round-key
// cache so repeated keys skip expansion.
// Ports: cipher_new_en/mode_decrypt/cipher_key/data_in (start, sampled when
// idle), data_out (held until next finish), cipher_finish (1-cycle done
// pulse), busy (operation in flight), key_miss (1-cycle pulse on expansion).
module aes_core_ed
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS       = 128,
  parameter bit          ENABLE_DECRYPT = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cipher_new_en,
  input  logic                mode_decrypt,
  input  logic [KEY_BITS-1:0] cipher_key,
  input  logic [127:0]        data_in,
  output logic [127:0]        data_out,
  output logic                cipher_finish,
  output logic                busy,
  output logic                key_miss
);

  localparam int unsigned NR        = nr_of(KEY_BITS);
  localparam logic [3:0]  NR4       = 4'(NR);
  localparam logic [3:0]  EXP_FIRST = (KEY_BITS == 256) ? 4'd2 : 4'd1;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_core_ed: KEY_BITS must be 128 or 256");
    end
  endgenerate

  fsm_t         state_q, state_d;
  logic [3:0]   cnt_q;
  logic         dec_q;
  state_t       st_q;
  state_t       enc_c, dec_c, round_c;

  logic         accept_c, hit_c, load_c, step_c;
  logic [3:0]   rd_idx_c;
  logic [127:0] rk_c;

  logic         finish_d, busy_d, miss_d;
  logic [127:0] data_out_d;

  assign accept_c = (state_q == ST_IDLE) && cipher_new_en;
  assign load_c   = accept_c && !hit_c;
  assign step_c   = (state_q == ST_EXPAND);
  // Decrypt walks the schedule backwards: RKNr first, RK0 last.
  assign rd_idx_c = dec_q ? (NR4 - cnt_q) : cnt_q;

  aes_key_cache #(.KEY_BITS(KEY_BITS)) u_key_cache (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_in   (cipher_key),
    .load     (load_c),
    .step     (step_c),
    .step_idx (cnt_q),
    .rd_idx   (rd_idx_c),
    .hit_c    (hit_c),
    .rd_key_c (rk_c)
  );

  // Forward round; MixColumns skipped in the final round.
  always_comb begin
    enc_c = shift_rows(sub_bytes(st_q));
    if (cnt_q != NR4) enc_c = mix_columns(enc_c);
    enc_c = enc_c ^ rk_c;
  end

  generate
    if (ENABLE_DECRYPT) begin : g_dec
      // Inverse-cipher round; InvMixColumns skipped in the final round.
      always_comb begin
        dec_c = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_c;
        if (cnt_q != NR4) dec_c = inv_mix_columns(dec_c);
      end
    end else begin : g_no_dec
      assign dec_c = '0;
    end
  endgenerate

  // Round counter 0 is the initial whitening AddRoundKey.
  assign round_c = (cnt_q == 4'd0) ? state_t'(st_q ^ rk_c) : (dec_q ? dec_c : enc_c);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cipher_new_en) state_d = hit_c ? ST_ROUND : ST_EXPAND;
      ST_EXPAND: if (cnt_q == NR4)  state_d = ST_ROUND;
      ST_ROUND:  if (cnt_q == NR4)  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output next values; registered below so DONE sees finish and result together.
  always_comb begin
    finish_d   = (state_q == ST_ROUND) && (cnt_q == NR4);
    busy_d     = (state_d == ST_EXPAND) || (state_d == ST_ROUND);
    miss_d     = load_c;
    data_out_d = data_out;
    if (finish_d) data_out_d = round_c;
  end

  // Datapath: counter, mode and working state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
      dec_q <= 1'b0;
      st_q  <= '0;
    end else if (accept_c) begin
      st_q  <= data_in;
      dec_q <= ENABLE_DECRYPT && mode_decrypt;
      cnt_q <= hit_c ? 4'd0 : EXP_FIRST;
    end else if (state_q == ST_EXPAND) begin
      cnt_q <= (cnt_q == NR4) ? 4'd0 : (cnt_q + 4'd1);
    end else if (state_q == ST_ROUND) begin
      st_q  <= round_c;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out      <= '0;
      cipher_finish <= 1'b0;
      busy          <= 1'b0;
      key_miss      <= 1'b0;
    end else begin
      data_out      <= data_out_d;
      cipher_finish <= finish_d;
      busy          <= busy_d;
      key_miss      <= miss_d;
    end
  end

endmodule

// File: tb/tb_aes_core_ed.sv
// Directed bench for aes_core_ed: AES-128 instance (u_a) and AES-256 instance (u_b).
module tb_aes_core_ed;

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KA5  = {16{8'ha5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic         start_a, mode_a, fin_a, busy_a, miss_a;
  logic [127:0] key_a, din_a, dout_a;
  logic         start_b, mode_b, fin_b, busy_b, miss_b;
  logic [255:0] key_b;
  logic [127:0] din_b, dout_b;

  int checks = 0;
  int failures = 0;

  aes_core_ed #(.KEY_BITS(128), .ENABLE_DECRYPT(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .cipher_new_en(start_a), .mode_decrypt(mode_a),
    .cipher_key(key_a), .data_in(din_a), .data_out(dout_a),
    .cipher_finish(fin_a), .busy(busy_a), .key_miss(miss_a));

  aes_core_ed #(.KEY_BITS(256), .ENABLE_DECRYPT(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .cipher_new_en(start_b), .mode_decrypt(mode_b),
    .cipher_key(key_b), .data_in(din_b), .data_out(dout_b),
    .cipher_finish(fin_b), .busy(busy_b), .key_miss(miss_b));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation and follow it to cipher_finish. cyc is the cycle the
  // finish is seen, counting the sampling edge as 0 (-1 on timeout). A second
  // start with different operands is pulsed at cycle inj (never if inj < 0).
  task automatic op(input bit sel, input logic mode, input logic [255:0] key,
                    input logic [127:0] din, input int inj, output int cyc,
                    output logic miss, output logic [127:0] dout,
                    output logic held, output int bcnt);
    logic [127:0] prev;
    @(negedge clk);
    prev = sel ? dout_b : dout_a;
    if (sel) begin mode_b = mode; key_b = key; din_b = din; start_b = 1'b1; end
    else     begin mode_a = mode; key_a = key[127:0]; din_a = din; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cyc = 0; held = 1'b1; bcnt = 0;
    miss = sel ? miss_b : miss_a;
    while (!(sel ? fin_b : fin_a) && cyc < 60) begin
      if ((sel ? dout_b : dout_a) !== prev) held = 1'b0;
      if (sel ? busy_b : busy_a) bcnt++;
      if (cyc == inj) begin
        if (sel) begin mode_b = ~mode; key_b = ~key; din_b = ~din; start_b = 1'b1; end
        else     begin mode_a = ~mode; key_a = ~key[127:0]; din_a = ~din; start_a = 1'b1; end
      end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      cyc++;
    end
    dout = sel ? dout_b : dout_a;
    if (cyc >= 60) cyc = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bcnt, nf;
    logic miss, held;
    logic [127:0] dout, ct_a5;

    reset_n = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; key_a = '0; din_a = '0;
    start_b = 1'b0; mode_b = 1'b0; key_b = '0; din_b = '0;
    repeat (3) @(negedge clk);
    check("rst_a_dout", dout_a, 128'h0);
    check("rst_a_fin",  128'(fin_a), 128'h0);
    check("rst_a_busy", 128'(busy_a), 128'h0);
    check("rst_a_miss", 128'(miss_a), 128'h0);
    check("rst_b_dout", dout_b, 128'h0);
    check("rst_b_fin",  128'(fin_b), 128'h0);
    check("rst_b_busy", 128'(busy_b), 128'h0);
    check("rst_b_miss", 128'(miss_b), 128'h0);
    reset_n = 1'b1;

    // AES-128 encrypt, cold cache
    op(1'b0, 1'b0, {128'h0, K128}, PT, -1, cyc, miss, dout, held, bcnt);
    check("e128_cyc",  128'(cyc), 128'd21);
    check("e128_miss", 128'(miss), 128'd1);
    check("e128_data", dout, C128);
    check("e128_busy_cycles", 128'(bcnt), 128'd21);
    check("e128_busy_at_finish", 128'(busy_a), 128'd0);
    @(negedge clk);
    check("e128_finish_pulse", 128'(fin_a), 128'd0);
    check("e128_dout_hold", dout_a, C128);

    // Same key, decrypt: cache hit
    op(1'b0, 1'b1, {128'h0, K128}, C128, -1, cyc, miss, dout, held, bcnt);
    check("d128_cyc",  128'(cyc), 128'd11);
    check("d128_miss", 128'(miss), 128'd0);
    check("d128_data", dout, PT);
    check("d128_busy_cycles", 128'(bcnt), 128'd11);

    // Start asserted in the finish cycle is ignored
    mode_a = 1'b0; key_a = K128; din_a = PT; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_at_finish_busy", 128'(busy_a), 128'd0);
    check("start_at_finish_miss", 128'(miss_a), 128'd0);
    nf = 0;
    repeat (30) begin @(negedge clk); if (fin_a) nf++; end
    check("start_at_finish_nofinish", 128'(nf), 128'd0);

    // Key change to FIPS-197 Appendix B key: miss, data_out holds until finish
    op(1'b0, 1'b0, {128'h0, KB}, PB, -1, cyc, miss, dout, held, bcnt);
    check("kb_cyc",  128'(cyc), 128'd21);
    check("kb_miss", 128'(miss), 128'd1);
    check("kb_data", dout, CB);
    check("kb_hold", 128'(held), 128'd1);

    // Key change to a5..a5: miss, then decrypt round-trip under the cached key
    op(1'b0, 1'b0, {128'h0, KA5}, PT, -1, cyc, miss, ct_a5, held, bcnt);
    check("a5_cyc",  128'(cyc), 128'd21);
    check("a5_miss", 128'(miss), 128'd1);
    check("a5_hold", 128'(held), 128'd1);
    op(1'b0, 1'b1, {128'h0, KA5}, ct_a5, -1, cyc, miss, dout, held, bcnt);
    check("a5_dec_cyc",  128'(cyc), 128'd11);
    check("a5_dec_miss", 128'(miss), 128'd0);
    check("a5_dec_data", dout, PT);

    // Start pulsed while busy with different operands is ignored
    op(1'b0, 1'b0, {128'h0, KA5}, PT, 3, cyc, miss, dout, held, bcnt);
    check("busy_ign_cyc",  128'(cyc), 128'd11);
    check("busy_ign_data", dout, ct_a5);
    check("busy_ign_busy_cycles", 128'(bcnt), 128'd11);
    nf = 0;
    repeat (30) begin @(negedge clk); if (fin_a) nf++; end
    check("busy_ign_single_finish", 128'(nf), 128'd0);

    // AES-256 encrypt cold, then decrypt hit
    op(1'b1, 1'b0, K256, PT, -1, cyc, miss, dout, held, bcnt);
    check("e256_cyc",  128'(cyc), 128'd28);
    check("e256_miss", 128'(miss), 128'd1);
    check("e256_data", dout, C256);
    op(1'b1, 1'b1, K256, C256, -1, cyc, miss, dout, held, bcnt);
    check("d256_cyc",  128'(cyc), 128'd15);
    check("d256_miss", 128'(miss), 128'd0);
    check("d256_data", dout, PT);

    // Reset during round processing aborts; rerun must miss again
    @(negedge clk);
    mode_a = 1'b0; key_a = K128; din_a = PT; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    nf = 0;
    repeat (15) begin @(negedge clk); if (fin_a) nf++; end
    reset_n = 1'b0;
    #1;
    check("midrst_dout", dout_a, 128'h0);
    check("midrst_busy", 128'(busy_a), 128'd0);
    check("midrst_miss", 128'(miss_a), 128'd0);
    repeat (3) begin @(negedge clk); if (fin_a) nf++; end
    check("midrst_nofinish", 128'(nf), 128'd0);
    reset_n = 1'b1;
    op(1'b0, 1'b0, {128'h0, K128}, PT, -1, cyc, miss, dout, held, bcnt);
    check("rerun_cyc",  128'(cyc), 128'd21);
    check("rerun_miss", 128'(miss), 128'd1);
    check("rerun_data", dout, C128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
